// File: rtl/rheed_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : rheed_pkg                                                    |
// | Description : Shared widths, slot layout and tkeep helper for the RHEED    |
// |               result packer.                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package rheed_pkg;

    localparam int SLOT_W   = 64;
    localparam int SLOTS    = 4;
    localparam int AXIS_W   = 256;
    localparam int RESULT_W = 40;
    localparam int KEEP_W   = AXIS_W / 8;
    localparam int TAG_W    = SLOT_W - RESULT_W;

    // One 64-bit slot: frame tag in the upper bits, CNN result in the lower bits.
    typedef struct packed {
        logic [TAG_W-1:0]    frame_idx;
        logic [RESULT_W-1:0] result;
    } result_slot_t;

    // Byte enables covering slots 0..slot (8 bytes per slot, from bit 0 upward).
    function automatic logic [KEEP_W-1:0] keep_for_slot(input logic [1:0] slot);
        logic [KEEP_W-1:0] all_ones;
        all_ones = '1;
        return all_ones >> (8 * (SLOTS - 1 - int'(slot)));
    endfunction

endpackage : rheed_pkg
`default_nettype wire

// File: rtl/rheed_result_packer_axis_out_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axis_out_reg                                                 |
// | Description : Single-entry AXI-Stream output register (data/keep/last)    |
// |               with EMPTY/FULL valid-ready control. A load in the same     |
// |               cycle as a drain replaces the word and keeps valid high.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module axis_out_reg
    import rheed_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [AXIS_W-1:0] i_data,
    input  logic [KEEP_W-1:0] i_keep,
    input  logic              i_last,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [AXIS_W-1:0] o_data,
    output logic [KEEP_W-1:0] o_keep,
    output logic              o_last
);

    localparam logic [0:0] c_st_empty = 1'b0;
    localparam logic [0:0] c_st_full  = 1'b1;

    logic [0:0]        r_state_q, w_state_d;
    logic [AXIS_W-1:0] r_data_q,  w_data_d;
    logic [KEEP_W-1:0] r_keep_q,  w_keep_d;
    logic              r_last_q,  w_last_d;

    // Next state: a load always wins (covers drain+load); otherwise a drain empties.
    always_comb begin
        w_state_d = r_state_q;
        w_data_d  = r_data_q;
        w_keep_d  = r_keep_q;
        w_last_d  = r_last_q;
        if (i_load) begin
            w_state_d = c_st_full;
            w_data_d  = i_data;
            w_keep_d  = i_keep;
            w_last_d  = i_last;
        end else if ((r_state_q == c_st_full) && i_ready) begin
            w_state_d = c_st_empty;
        end
    end

    // Register the word; payload only changes on a load so it holds during stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= c_st_empty;
            r_data_q  <= '0;
            r_keep_q  <= '0;
            r_last_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_data_q  <= w_data_d;
            r_keep_q  <= w_keep_d;
            r_last_q  <= w_last_d;
        end
    end

    assign o_valid = (r_state_q == c_st_full);
    assign o_data  = r_data_q;
    assign o_keep  = r_keep_q;
    assign o_last  = r_last_q;

endmodule : axis_out_reg
`default_nettype wire

// File: rtl/rheed_result_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rheed_result_packer                                          |
// | Description : Tags 40-bit CNN results with the frame index and packs four  |
// |               per 256-bit AXI-Stream word; a word closes when full or at  |
// |               frame end, and tlast marks the last word of each frame.     |
// |               Optional statistics ports: RESULT_PACKER_STATS_EN.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rheed_result_packer
    import rheed_pkg::*;
#(
    parameter int RESULTS_PER_FRAME = 6,
    parameter int FRAME_IDX_W       = 24
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [RESULT_W-1:0]    s_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [AXIS_W-1:0]      m_axis_tdata,
    output logic [KEEP_W-1:0]      m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic [FRAME_IDX_W-1:0] frame_idx,
`ifdef RESULT_PACKER_STATS_EN
    output logic [31:0]            stat_words,
    output logic [31:0]            stat_stall,
`endif
    output logic                   busy
);

    localparam int c_res_w = (RESULTS_PER_FRAME > 1) ? $clog2(RESULTS_PER_FRAME) : 1;
    localparam logic [c_res_w-1:0] c_res_last = c_res_w'(RESULTS_PER_FRAME - 1);

    if ((RESULTS_PER_FRAME < 1) || (FRAME_IDX_W + RESULT_W != SLOT_W)) begin : g_cfg_check
        $error("rheed_result_packer: RESULTS_PER_FRAME must be >=1 and FRAME_IDX_W+40 must be 64");
    end

    logic [1:0]                    r_slot_cnt_q,  w_slot_cnt_d;
    logic [c_res_w-1:0]            r_res_cnt_q,   w_res_cnt_d;
    logic [FRAME_IDX_W-1:0]        r_frame_idx_q, w_frame_idx_d;
    logic [SLOTS-1:0][SLOT_W-1:0]  r_acc_q,       w_acc_d;

    logic                          w_complete;
    logic                          w_frame_end;
    logic                          w_accept;
    logic                          w_load;
    result_slot_t                  w_new_slot;
    logic [SLOTS-1:0][SLOT_W-1:0]  w_word;

    // The closing condition depends on the counters only, so tready never sees tvalid.
    assign w_frame_end   = (r_res_cnt_q == c_res_last);
    assign w_complete    = (r_slot_cnt_q == 2'd3) || w_frame_end;
    assign s_axis_tready = !w_complete || !m_axis_tvalid || m_axis_tready;
    assign w_accept      = s_axis_tvalid && s_axis_tready;
    assign w_load        = w_accept && w_complete;
    assign w_new_slot    = {r_frame_idx_q, s_axis_tdata};

    // Closing word: filled slots from the accumulator, new result in the current slot, zeros above.
    always_comb begin
        w_word = '0;
        for (int k = 0; k < SLOTS; k++) begin
            if (2'(k) == r_slot_cnt_q) begin
                w_word[k] = w_new_slot;
            end else if (2'(k) < r_slot_cnt_q) begin
                w_word[k] = r_acc_q[k];
            end else begin
                w_word[k] = '0;
            end
        end
    end

    // Counter, accumulator and frame-tag updates on each accepted result.
    always_comb begin
        w_slot_cnt_d  = r_slot_cnt_q;
        w_res_cnt_d   = r_res_cnt_q;
        w_frame_idx_d = r_frame_idx_q;
        w_acc_d       = r_acc_q;
        if (w_accept) begin
            if (w_complete) begin
                w_acc_d      = '0;
                w_slot_cnt_d = 2'd0;
            end else begin
                w_acc_d[r_slot_cnt_q] = w_new_slot;
                w_slot_cnt_d          = r_slot_cnt_q + 2'd1;
            end
            if (w_frame_end) begin
                w_res_cnt_d   = '0;
                w_frame_idx_d = r_frame_idx_q + 1'b1;
            end else begin
                w_res_cnt_d   = r_res_cnt_q + 1'b1;
            end
        end
    end

    // Packing state; reset discards any partial word and restarts frame numbering.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot_cnt_q  <= 2'd0;
            r_res_cnt_q   <= '0;
            r_frame_idx_q <= '0;
            r_acc_q       <= '0;
        end else begin
            r_slot_cnt_q  <= w_slot_cnt_d;
            r_res_cnt_q   <= w_res_cnt_d;
            r_frame_idx_q <= w_frame_idx_d;
            r_acc_q       <= w_acc_d;
        end
    end

    axis_out_reg u_out_reg (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_data  (w_word),
        .i_keep  (keep_for_slot(r_slot_cnt_q)),
        .i_last  (w_frame_end),
        .i_ready (m_axis_tready),
        .o_valid (m_axis_tvalid),
        .o_data  (m_axis_tdata),
        .o_keep  (m_axis_tkeep),
        .o_last  (m_axis_tlast)
    );

    assign frame_idx = r_frame_idx_q;
    // Slot count is non-zero only inside a frame, so the result counter alone marks a partial frame.
    assign busy      = (r_res_cnt_q != '0) || m_axis_tvalid;

`ifdef RESULT_PACKER_STATS_EN
    logic [31:0] r_stat_words_q, w_stat_words_d;
    logic [31:0] r_stat_stall_q, w_stat_stall_d;

    // Free-running wrap-around counters of output handshakes and stalled cycles.
    always_comb begin
        w_stat_words_d = r_stat_words_q;
        w_stat_stall_d = r_stat_stall_q;
        if (m_axis_tvalid && m_axis_tready) begin
            w_stat_words_d = r_stat_words_q + 32'd1;
        end
        if (m_axis_tvalid && !m_axis_tready) begin
            w_stat_stall_d = r_stat_stall_q + 32'd1;
        end
    end

    // Statistics registers, cleared with the rest of the block.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_words_q <= '0;
            r_stat_stall_q <= '0;
        end else begin
            r_stat_words_q <= w_stat_words_d;
            r_stat_stall_q <= w_stat_stall_d;
        end
    end

    assign stat_words = r_stat_words_q;
    assign stat_stall = r_stat_stall_q;
`endif

endmodule : rheed_result_packer
`default_nettype wire

// File: tb/tb_rheed_result_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_rheed_result_packer                                       |
// | Description : Scoreboard bench for rheed_result_packer. Instance A (6      |
// |               results/frame) is scoreboarded; B (1/frame) exercises the   |
// |               tag wrap; C (16/frame) exercises deep input absorption.     |
// |               Statistics checks are compiled with RESULT_PACKER_STATS_EN. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_rheed_result_packer;
    import rheed_pkg::*;

    localparam int c_rpf_a = 6;
    localparam int c_rpf_b = 1;
    localparam int c_rpf_c = 16;

    typedef struct packed {
        logic [AXIS_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
    } word_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Instance A signals
    logic a_s_valid, a_s_ready, a_m_valid, a_m_ready, a_m_last, a_busy;
    logic [RESULT_W-1:0] a_s_data;
    logic [AXIS_W-1:0]   a_m_data;
    logic [KEEP_W-1:0]   a_m_keep;
    logic [23:0]         a_frame_idx;
    // Instance B signals
    logic b_s_valid, b_s_ready, b_m_valid, b_m_ready, b_m_last, b_busy;
    logic [RESULT_W-1:0] b_s_data;
    logic [AXIS_W-1:0]   b_m_data;
    logic [KEEP_W-1:0]   b_m_keep;
    logic [23:0]         b_frame_idx;
    // Instance C signals
    logic c_s_valid, c_s_ready, c_m_valid, c_m_ready, c_m_last, c_busy;
    logic [RESULT_W-1:0] c_s_data;
    logic [AXIS_W-1:0]   c_m_data;
    logic [KEEP_W-1:0]   c_m_keep;
    logic [23:0]         c_frame_idx;
`ifdef RESULT_PACKER_STATS_EN
    logic [31:0] a_stat_words, a_stat_stall, b_stat_words, b_stat_stall, c_stat_words, c_stat_stall;
`endif

    rheed_result_packer #(.RESULTS_PER_FRAME(c_rpf_a), .FRAME_IDX_W(24)) dut_a (
        .clk(clk), .reset(reset),
        .s_axis_tvalid(a_s_valid), .s_axis_tready(a_s_ready), .s_axis_tdata(a_s_data),
        .m_axis_tvalid(a_m_valid), .m_axis_tready(a_m_ready), .m_axis_tdata(a_m_data),
        .m_axis_tkeep(a_m_keep), .m_axis_tlast(a_m_last), .frame_idx(a_frame_idx),
`ifdef RESULT_PACKER_STATS_EN
        .stat_words(a_stat_words), .stat_stall(a_stat_stall),
`endif
        .busy(a_busy)
    );

    rheed_result_packer #(.RESULTS_PER_FRAME(c_rpf_b), .FRAME_IDX_W(24)) dut_b (
        .clk(clk), .reset(reset),
        .s_axis_tvalid(b_s_valid), .s_axis_tready(b_s_ready), .s_axis_tdata(b_s_data),
        .m_axis_tvalid(b_m_valid), .m_axis_tready(b_m_ready), .m_axis_tdata(b_m_data),
        .m_axis_tkeep(b_m_keep), .m_axis_tlast(b_m_last), .frame_idx(b_frame_idx),
`ifdef RESULT_PACKER_STATS_EN
        .stat_words(b_stat_words), .stat_stall(b_stat_stall),
`endif
        .busy(b_busy)
    );

    rheed_result_packer #(.RESULTS_PER_FRAME(c_rpf_c), .FRAME_IDX_W(24)) dut_c (
        .clk(clk), .reset(reset),
        .s_axis_tvalid(c_s_valid), .s_axis_tready(c_s_ready), .s_axis_tdata(c_s_data),
        .m_axis_tvalid(c_m_valid), .m_axis_tready(c_m_ready), .m_axis_tdata(c_m_data),
        .m_axis_tkeep(c_m_keep), .m_axis_tlast(c_m_last), .frame_idx(c_frame_idx),
`ifdef RESULT_PACKER_STATS_EN
        .stat_words(c_stat_words), .stat_stall(c_stat_stall),
`endif
        .busy(c_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model for instance A
    logic [AXIS_W-1:0] m_acc;
    int                m_slot, m_res;
    logic [23:0]       m_frame;
    word_t             sb_q[$];
    word_t             got_q[$];
    int                n_acc = 0, n_words = 0, n_lasts = 0;
    logic              stall_prev;
    word_t             hold;

    task automatic model_reset();
        m_acc = '0; m_slot = 0; m_res = 0; m_frame = '0;
        sb_q.delete();
        stall_prev = 1'b0;
    endtask

    task automatic model_push(input logic [RESULT_W-1:0] d);
        word_t w;
        m_acc[64*m_slot +: 64] = {m_frame, d};
        if (m_slot == 3 || m_res == c_rpf_a - 1) begin
            w.data = m_acc;
            case (m_slot)
                0:       w.keep = 32'h0000_00FF;
                1:       w.keep = 32'h0000_FFFF;
                2:       w.keep = 32'h00FF_FFFF;
                default: w.keep = 32'hFFFF_FFFF;
            endcase
            w.last = (m_res == c_rpf_a - 1);
            sb_q.push_back(w);
            m_acc  = '0;
            m_slot = 0;
        end else begin
            m_slot++;
        end
        if (m_res == c_rpf_a - 1) begin
            m_res = 0;
            m_frame++;
        end else begin
            m_res++;
        end
    endtask

    // One cycle of instance A: drive at negedge, judge handshakes, advance past posedge.
    task automatic step_a(input logic sv, input logic [RESULT_W-1:0] sd, input logic mr, output logic acc);
        word_t e;
        a_s_valid = sv; a_s_data = sd; a_m_ready = mr;
        #1;
        if (stall_prev) begin
            chk("hold_valid", 256'(a_m_valid), 256'(1));
            chk("hold_data",  a_m_data, hold.data);
            chk("hold_keep",  256'(a_m_keep), 256'(hold.keep));
            chk("hold_last",  256'(a_m_last), 256'(hold.last));
        end
        if (a_m_valid && a_m_ready) begin
            chk("word_expected", 256'(sb_q.size() != 0), 256'(1));
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("word_data", a_m_data, e.data);
                chk("word_keep", 256'(a_m_keep), 256'(e.keep));
                chk("word_last", 256'(a_m_last), 256'(e.last));
            end
            got_q.push_back({a_m_data, a_m_keep, a_m_last});
            n_words++;
            if (a_m_last) n_lasts++;
        end
        stall_prev = a_m_valid && !a_m_ready;
        hold       = {a_m_data, a_m_keep, a_m_last};
        acc        = sv && a_s_ready && !reset;
        if (acc) begin
            model_push(sd);
            n_acc++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic              acc;
        logic [RESULT_W-1:0] v;
        logic [63:0]       r64;
        int                acc0, w0, l0, cnt;
        word_t             c_words[$];

        a_s_valid = 0; a_s_data = '0; a_m_ready = 0;
        b_s_valid = 0; b_s_data = '0; b_m_ready = 0;
        c_s_valid = 0; c_s_data = '0; c_m_ready = 0;
        model_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        // Reset state
        chk("rst_tvalid", 256'(a_m_valid), 256'(0));
        chk("rst_tdata",  a_m_data, 256'(0));
        chk("rst_tkeep",  256'(a_m_keep), 256'(0));
        chk("rst_tlast",  256'(a_m_last), 256'(0));
        chk("rst_tready", 256'(a_s_ready), 256'(1));
        chk("rst_frame",  256'(a_frame_idx), 256'(0));
        chk("rst_busy",   256'(a_busy), 256'(0));
        @(negedge clk);

        // Back-to-back frame, downstream always ready
        got_q.delete();
        acc0 = n_acc;
        for (int i = 1; i <= 6; i++) step_a(1'b1, RESULT_W'(i), 1'b1, acc);
        chk("b2b_accepted", 256'(n_acc - acc0), 256'(6));
        repeat (3) step_a(1'b0, '0, 1'b1, acc);
        chk("b2b_words", 256'(got_q.size()), 256'(2));
        if (got_q.size() >= 2) begin
            chk("b2b_w0_keep",  256'(got_q[0].keep), 256'(32'hFFFF_FFFF));
            chk("b2b_w0_last",  256'(got_q[0].last), 256'(0));
            chk("b2b_w0_slot0", 256'(got_q[0].data[63:0]), 256'(64'h0000_0000_0000_0001));
            chk("b2b_w1_keep",  256'(got_q[1].keep), 256'(32'h0000_FFFF));
            chk("b2b_w1_last",  256'(got_q[1].last), 256'(1));
            chk("b2b_w1_upper", 256'(got_q[1].data[255:128]), 256'(0));
        end
        chk("b2b_frame_idx", 256'(a_frame_idx), 256'(1));

        // Held backpressure: 4 results fill a word, then only one more fits before the frame-closing beat
        got_q.delete();
        acc0 = n_acc;
        v = 40'h100;
        repeat (20) begin
            step_a(1'b1, v, 1'b0, acc);
            if (acc) v++;
        end
        chk("bp_accepted", 256'(n_acc - acc0), 256'(5));
        chk("bp_tready_low", 256'(a_s_ready), 256'(0));
        chk("bp_word_pending", 256'(a_m_valid), 256'(1));
        for (int cyc = 0; cyc < 40 && (n_acc - acc0) < 12; cyc++) begin
            step_a(1'b1, v, 1'b1, acc);
            if (acc) v++;
        end
        repeat (4) step_a(1'b0, '0, 1'b1, acc);
        chk("bp_total_accepted", 256'(n_acc - acc0), 256'(12));
        chk("bp_words", 256'(got_q.size()), 256'(4));
        chk("bp_sb_empty", 256'(sb_q.size()), 256'(0));

        // Random downstream readiness over 100 frames
        acc0 = n_acc; w0 = n_words; l0 = n_lasts;
        r64 = {$urandom(), $urandom()};
        v = r64[39:0];
        for (int cyc = 0; cyc < 5000 && (n_acc - acc0) < 600; cyc++) begin
            step_a(1'b1, v, 1'($urandom_range(0, 1)), acc);
            if (acc) begin
                r64 = {$urandom(), $urandom()};
                v = r64[39:0];
            end
        end
        repeat (6) step_a(1'b0, '0, 1'b1, acc);
        chk("rand_accepted", 256'(n_acc - acc0), 256'(600));
        chk("rand_words",    256'(n_words - w0), 256'(200));
        chk("rand_lasts",    256'(n_lasts - l0), 256'(100));
        chk("rand_sb_empty", 256'(sb_q.size()), 256'(0));
        chk("rand_frame",    256'(a_frame_idx), 256'(m_frame));

        // Reset after 2 of 6 results
        w0 = n_words;
        step_a(1'b1, 40'hAA, 1'b1, acc);
        step_a(1'b1, 40'hBB, 1'b1, acc);
        chk("mid_busy", 256'(a_busy), 256'(1));
        reset = 1'b1;
        repeat (2) step_a(1'b0, '0, 1'b1, acc);
        reset = 1'b0;
        #1;
        chk("mid_rst_tvalid", 256'(a_m_valid), 256'(0));
        chk("mid_rst_frame",  256'(a_frame_idx), 256'(0));
        chk("mid_rst_busy",   256'(a_busy), 256'(0));
        chk("mid_rst_tready", 256'(a_s_ready), 256'(1));
        chk("mid_rst_nowords", 256'(n_words - w0), 256'(0));
        model_reset();
        @(negedge clk);

        // Fresh frames after reset: 10 stalled cycles, then 4 words total
        got_q.delete();
        acc0 = n_acc;
        v = 40'h200;
        for (int i = 0; i < 4; i++) begin
            step_a(1'b1, v, 1'b0, acc);
            if (acc) v++;
        end
        repeat (10) step_a(1'b0, '0, 1'b0, acc);
        for (int cyc = 0; cyc < 30 && (n_acc - acc0) < 12; cyc++) begin
            step_a(1'b1, v, 1'b1, acc);
            if (acc) v++;
        end
        repeat (4) step_a(1'b0, '0, 1'b1, acc);
        chk("post_rst_words", 256'(got_q.size()), 256'(4));
        if (got_q.size() >= 1)
            chk("post_rst_slot0", 256'(got_q[0].data[63:0]), 256'({24'd0, 40'h200}));
        chk("post_rst_sb_empty", 256'(sb_q.size()), 256'(0));
`ifdef RESULT_PACKER_STATS_EN
        chk("stat_stall", 256'(a_stat_stall), 256'(10));
        chk("stat_words", 256'(a_stat_words), 256'(4));
`endif

        // Instance C: absorb 3 non-completing results behind a stalled word
        c_m_ready = 1'b0; c_s_valid = 1'b1; v = 40'd1; cnt = 0;
        repeat (20) begin
            c_s_data = v;
            #1;
            acc = c_s_ready;
            @(posedge clk);
            @(negedge clk);
            if (acc) begin v++; cnt++; end
        end
        c_s_data = v;
        #1;
        chk("c_accepted", 256'(cnt), 256'(7));
        chk("c_tready_low", 256'(c_s_ready), 256'(0));
        chk("c_pending_keep", 256'(c_m_keep), 256'(32'hFFFF_FFFF));
        c_m_ready = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            c_s_valid = (v <= 40'd16);
            c_s_data  = v;
            #1;
            if (c_m_valid && c_m_ready) c_words.push_back({c_m_data, c_m_keep, c_m_last});
            acc = c_s_valid && c_s_ready;
            @(posedge clk);
            @(negedge clk);
            if (acc) v++;
        end
        chk("c_words", 256'(c_words.size()), 256'(4));
        if (c_words.size() == 4) begin
            chk("c_w0_slot0", 256'(c_words[0].data[63:0]),    256'({24'd0, 40'd1}));
            chk("c_w0_slot3", 256'(c_words[0].data[255:192]), 256'({24'd0, 40'd4}));
            chk("c_w1_slot0", 256'(c_words[1].data[63:0]),    256'({24'd0, 40'd5}));
            chk("c_w2_last",  256'(c_words[2].last), 256'(0));
            chk("c_w3_last",  256'(c_words[3].last), 256'(1));
            chk("c_w3_slot3", 256'(c_words[3].data[255:192]), 256'({24'd0, 40'd16}));
        end
        chk("c_frame_idx", 256'(c_frame_idx), 256'(1));
        chk("c_idle_busy", 256'(c_busy), 256'(0));
`ifdef RESULT_PACKER_STATS_EN
        chk("c_stat_words", 256'(c_stat_words), 256'(4));
        chk("c_stat_stall", 256'(c_stat_stall), 256'(16));
`endif

        // Instance B: one result per frame, frame tag wrapping from all ones
        force dut_b.r_frame_idx_q = 24'hFF_FFFF;
        #1;
        release dut_b.r_frame_idx_q;
        #1;
        chk("b_forced_tag", 256'(b_frame_idx), 256'(24'hFF_FFFF));
        b_s_valid = 1'b1; b_s_data = 40'hAB; b_m_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_s_data = 40'hCD;
        #1;
        chk("b_wrap_valid", 256'(b_m_valid), 256'(1));
        chk("b_wrap_keep",  256'(b_m_keep), 256'(32'h0000_00FF));
        chk("b_wrap_last",  256'(b_m_last), 256'(1));
        chk("b_wrap_slot0", 256'(b_m_data[63:0]), 256'({24'hFF_FFFF, 40'hAB}));
        chk("b_wrap_upper", 256'(b_m_data[255:64]), 256'(0));
        chk("b_wrap_tag",   256'(b_frame_idx), 256'(0));
        @(posedge clk);
        @(negedge clk);
        b_s_valid = 1'b0;
        #1;
        chk("b_next_valid", 256'(b_m_valid), 256'(1));
        chk("b_next_slot0", 256'(b_m_data[63:0]), 256'({24'h00_0000, 40'hCD}));
        chk("b_next_frame", 256'(b_frame_idx), 256'(1));
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("b_drained_busy", 256'(b_busy), 256'(0));
`ifdef RESULT_PACKER_STATS_EN
        chk("b_stat_words", 256'(b_stat_words), 256'(2));
        chk("b_stat_stall", 256'(b_stat_stall), 256'(0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_rheed_result_packer
`default_nettype wire
